// File: rtl/hilo_ctrl.sv
// hilo_ctrl -- HI/LO register file and multiply/divide sequencing controller.
//
// Decodes the HI/LO family of R-type instructions. MTHI/MTLO write the
// architectural registers directly; MULT/MULTU/DIV/DIVU latch the operands,
// start the corresponding external unit and stall the front end until the
// unit answers or the watchdog expires. A divide by zero is silently dropped.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   op_valid, funct         R-type instruction in execute and its function field
//   SrcA, SrcB              rs / rt operands
//   mul_validIn, mul_sign   multiplier start request (held while waiting), signed select
//   mul_validOut            multiplier result valid
//   mul_Hi, mul_Lo          multiplier result
//   div_validIn, div_sign   divider start request (held while waiting), signed select
//   div_validOut            divider result valid
//   div_Hi, div_Lo          divider remainder / quotient
//   opA, opB                operands latched at start, shared by both units
//   stall                   front-end freeze
//   hilo_rd                 MFHI/MFLO read data
//   Hi, Lo                  architectural HI/LO registers
//   timeout_err             sticky watchdog flag
module hilo_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        mul_validIn,
    output logic        mul_sign,
    input  logic        mul_validOut,
    input  logic [31:0] mul_Hi,
    input  logic [31:0] mul_Lo,
    output logic        div_validIn,
    output logic        div_sign,
    input  logic        div_validOut,
    input  logic [31:0] div_Hi,
    input  logic [31:0] div_Lo,
    output logic [31:0] opA,
    output logic [31:0] opB,
    output logic        stall,
    output logic [31:0] hilo_rd,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MUL_WAIT = 2'd1;
    localparam logic [1:0] DIV_WAIT = 2'd2;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [CW-1:0] wd_cnt;
    logic          in_idle;
    logic          start_mul;
    logic          start_div;
    logic          do_mthi;
    logic          do_mtlo;
    logic          wd_expire;

    // Instruction decode only matters in IDLE; in a WAIT state the
    // front end is frozen and op_valid/funct are ignored.
    assign in_idle   = (state == IDLE);
    assign start_mul = in_idle && op_valid && (funct == F_MULT || funct == F_MULTU);
    assign start_div = in_idle && op_valid && (funct == F_DIV || funct == F_DIVU)
                       && (SrcB != '0);
    assign do_mthi   = in_idle && op_valid && (funct == F_MTHI);
    assign do_mtlo   = in_idle && op_valid && (funct == F_MTLO);

    // Counter holds the number of completed WAIT cycles; the TIMEOUT-th
    // WAIT cycle without a response is the last one.
    assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1));

    assign mul_validIn = (state == MUL_WAIT);
    assign div_validIn = (state == DIV_WAIT);

    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:     stall = start_mul || start_div;
            MUL_WAIT: stall = !mul_validOut;
            DIV_WAIT: stall = !div_validOut;
            default:  stall = 1'b0;
        endcase
    end

    // Read data reflects the registers before any same-cycle write.
    always_comb begin
        hilo_rd = '0;
        if (funct == F_MFHI)
            hilo_rd = Hi;
        else if (funct == F_MFLO)
            hilo_rd = Lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            Hi          <= '0;
            Lo          <= '0;
            opA         <= '0;
            opB         <= '0;
            mul_sign    <= 1'b0;
            div_sign    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_mul) begin
                        opA      <= SrcA;
                        opB      <= SrcB;
                        mul_sign <= ~funct[0];
                        wd_cnt   <= '0;
                        state    <= MUL_WAIT;
                    end else if (start_div) begin
                        opA      <= SrcA;
                        opB      <= SrcB;
                        div_sign <= ~funct[0];
                        wd_cnt   <= '0;
                        state    <= DIV_WAIT;
                    end else if (do_mthi) begin
                        Hi <= SrcA;
                    end else if (do_mtlo) begin
                        Lo <= SrcA;
                    end
                end
                MUL_WAIT: begin
                    if (mul_validOut) begin
                        Hi    <= mul_Hi;
                        Lo    <= mul_Lo;
                        state <= IDLE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (div_validOut) begin
                        Hi    <= div_Hi;
                        Lo    <= div_Lo;
                        state <= IDLE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl -- self-checking bench for hilo_ctrl.
//
// The bench plays both arithmetic units: it answers a start request after a
// chosen number of WAIT cycles with the true product / quotient+remainder of
// the operands it issued, and sprinkles stray validOut pulses on the unit that
// is not being waited on. A transaction-level model predicts every output on
// every cycle; directed scenarios add literal expectations.
module tb_hilo_ctrl;

    localparam int TO = 8;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] SrcA, SrcB;
    logic        mul_validIn, mul_sign, mul_validOut;
    logic [31:0] mul_Hi, mul_Lo;
    logic        div_validIn, div_sign, div_validOut;
    logic [31:0] div_Hi, div_Lo;
    logic [31:0] opA, opB;
    logic        stall;
    logic [31:0] hilo_rd, Hi, Lo;
    logic        timeout_err;

    always #5 clk = ~clk;

    hilo_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .funct(funct), .SrcA(SrcA), .SrcB(SrcB),
        .mul_validIn(mul_validIn), .mul_sign(mul_sign), .mul_validOut(mul_validOut),
        .mul_Hi(mul_Hi), .mul_Lo(mul_Lo),
        .div_validIn(div_validIn), .div_sign(div_sign), .div_validOut(div_validOut),
        .div_Hi(div_Hi), .div_Lo(div_Lo),
        .opA(opA), .opB(opB), .stall(stall), .hilo_rd(hilo_rd),
        .Hi(Hi), .Lo(Lo), .timeout_err(timeout_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: which unit is outstanding (0 none, 1 mul, 2 div) and how many
    // WAIT cycles it has already spent.
    int          m_pend;
    int          m_waited;
    logic [31:0] m_hi, m_lo, m_opa, m_opb;
    logic        m_msign, m_dsign, m_err;
    int          cur_lat;          // response arrives in this WAIT cycle (1-based)
    int          stall_wait_cnt;   // DUT stall cycles seen while a unit is outstanding

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mul_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, p;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            return 64'(p);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Returns {remainder, quotient}.
    function automatic logic [63:0] div_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_waited = 0;
        m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0;
        m_msign = 1'b0; m_dsign = 1'b0; m_err = 1'b0;
    endtask

    // One clock cycle, entered just after a falling edge. spur: 0 = no stray
    // validOut, 1 = random stray validOut, 2 = stray validOut forced high.
    task automatic step(input logic opv, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int spur);
        logic        mvo, dvo, start_m, start_d, e_stall;
        logic [31:0] e_rd;
        logic [63:0] r;
        op_valid = opv; funct = f; SrcA = a; SrcB = b;
        mul_Hi = $urandom; mul_Lo = $urandom; div_Hi = $urandom; div_Lo = $urandom;
        mvo = 1'b0; dvo = 1'b0;
        if (m_pend != 1) mvo = (spur == 2) ? 1'b1 : (spur == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (m_pend != 2) dvo = (spur == 2) ? 1'b1 : (spur == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (m_pend == 1 && m_waited + 1 == cur_lat) begin
            mvo = 1'b1;
            r = mul_res(m_opa, m_opb, m_msign);
            mul_Hi = r[63:32]; mul_Lo = r[31:0];
        end
        if (m_pend == 2 && m_waited + 1 == cur_lat) begin
            dvo = 1'b1;
            r = div_res(m_opa, m_opb, m_dsign);
            div_Hi = r[63:32]; div_Lo = r[31:0];
        end
        mul_validOut = mvo; div_validOut = dvo;
        #1;
        start_m = (m_pend == 0) && opv && (f == MULT || f == MULTU);
        start_d = (m_pend == 0) && opv && (f == DIV || f == DIVU) && (b != 0);
        if (m_pend == 0)      e_stall = start_m || start_d;
        else if (m_pend == 1) e_stall = !mvo;
        else                  e_stall = !dvo;
        e_rd = (f == MFHI) ? m_hi : (f == MFLO) ? m_lo : 32'h0;
        chk1("stall", stall, e_stall);
        chk1("mul_validIn", mul_validIn, m_pend == 1);
        chk1("div_validIn", div_validIn, m_pend == 2);
        chk32("hilo_rd", hilo_rd, e_rd);
        chk32("Hi", Hi, m_hi);
        chk32("Lo", Lo, m_lo);
        chk32("opA", opA, m_opa);
        chk32("opB", opB, m_opb);
        chk1("mul_sign", mul_sign, m_msign);
        chk1("div_sign", div_sign, m_dsign);
        chk1("timeout_err", timeout_err, m_err);
        if (m_pend != 0 && stall) stall_wait_cnt++;
        if (m_pend == 0) begin
            if (start_m) begin
                m_opa = a; m_opb = b; m_msign = !f[0]; m_pend = 1; m_waited = 0;
            end else if (start_d) begin
                m_opa = a; m_opb = b; m_dsign = !f[0]; m_pend = 2; m_waited = 0;
            end else if (opv && f == MTHI) begin
                m_hi = a;
            end else if (opv && f == MTLO) begin
                m_lo = a;
            end
        end else if ((m_pend == 1 && mvo) || (m_pend == 2 && dvo)) begin
            r = (m_pend == 1) ? mul_res(m_opa, m_opb, m_msign) : div_res(m_opa, m_opb, m_dsign);
            m_hi = r[63:32]; m_lo = r[31:0]; m_pend = 0;
        end else if (m_waited + 1 == TO) begin
            m_err = 1'b1; m_pend = 0;
        end else begin
            m_waited++;
        end
        @(negedge clk);
    endtask

    // Start an operation and run idle cycles until it completes (bounded).
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int lat);
        cur_lat = lat;
        stall_wait_cnt = 0;
        step(1'b1, f, a, b, 1);
        for (int i = 0; i < 3 * TO && m_pend != 0; i++)
            step(1'b0, f, a, b, 1);
    endtask

    task automatic peek_rd(input logic [5:0] f, input logic [31:0] exp, input string name);
        op_valid = 1'b0; funct = f;
        #1;
        chk32(name, hilo_rd, exp);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] b;
        int          k;
        reset = 1'b1; op_valid = 1'b0; funct = '0; SrcA = '0; SrcB = '0;
        mul_validOut = 1'b0; div_validOut = 1'b0;
        mul_Hi = '0; mul_Lo = '0; div_Hi = '0; div_Lo = '0;
        model_reset();
        cur_lat = 1; stall_wait_cnt = 0;
        #1;
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mul_validIn", mul_validIn, 1'b0);
        chk1("rst_div_validIn", div_validIn, 1'b0);
        chk32("rst_Hi", Hi, 32'h0);
        chk32("rst_Lo", Lo, 32'h0);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Signed multiply, unit answers in the 5th WAIT cycle.
        run_op(MULT, 32'hFFFF_FFFE, 32'd3, 5);
        chk32("mult_wait_stalls", 32'(stall_wait_cnt), 32'd4);
        chk32("mult_Hi", Hi, 32'hFFFF_FFFF);
        chk32("mult_Lo", Lo, 32'hFFFF_FFFA);
        chk1("mult_sign", mul_sign, 1'b1);

        // Unsigned divide then immediate MFLO.
        run_op(DIVU, 32'd100, 32'd7, 3);
        chk1("divu_sign", div_sign, 1'b0);
        chk32("divu_Lo", Lo, 32'd14);
        chk32("divu_Hi", Hi, 32'd2);
        peek_rd(MFLO, 32'd14, "mflo_after_divu");

        // Divide by zero is dropped.
        run_op(DIV, 32'd55, 32'd0, 2);
        step(1'b0, DIV, 32'd55, 32'd0, 0);
        chk32("div0_Hi", Hi, 32'd2);
        chk32("div0_Lo", Lo, 32'd14);
        chk32("div0_stalls", 32'(stall_wait_cnt), 32'd0);

        // MTHI then MFHI.
        step(1'b1, MTHI, 32'h1234_5678, 32'h0, 1);
        peek_rd(MFHI, 32'h1234_5678, "mfhi_after_mthi");
        chk1("mthi_no_stall", stall, 1'b0);

        // Unit never responds: watchdog.
        run_op(MULTU, 32'hDEAD_BEEF, 32'h1111, 1000);
        chk32("to_wait_stalls", 32'(stall_wait_cnt), 32'd8);
        chk1("to_err", timeout_err, 1'b1);
        chk1("to_idle", mul_validIn, 1'b0);
        chk32("to_Hi", Hi, 32'h1234_5678);
        chk32("to_Lo", Lo, 32'd14);

        // Reset in the 2nd MUL_WAIT cycle; a later validOut must not write.
        cur_lat = 6;
        step(1'b1, MULT, 32'd7, 32'd9, 0);
        step(1'b0, MULT, 32'd7, 32'd9, 0);
        op_valid = 1'b0; mul_validOut = 1'b0; div_validOut = 1'b0;
        reset = 1'b1;
        #1;
        chk1("midrst_stall", stall, 1'b0);
        chk1("midrst_mul_validIn", mul_validIn, 1'b0);
        chk32("midrst_Hi", Hi, 32'h0);
        chk32("midrst_Lo", Lo, 32'h0);
        chk32("midrst_opA", opA, 32'h0);
        chk1("midrst_err", timeout_err, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, MULT, 32'd7, 32'd9, 2);
        chk32("postrst_Hi", Hi, 32'h0);
        chk32("postrst_Lo", Lo, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom_range(0, 9));
            case (k)
                0: f = MFHI;  1: f = MTHI;  2: f = MFLO;  3: f = MTLO;
                4: f = MULT;  5: f = MULTU; 6: f = DIV;   7: f = DIVU;
                default: f = 6'($urandom);
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            if (m_pend == 0) cur_lat = int'($urandom_range(1, TO + 3));
            step(1'($urandom_range(0, 3) != 0), f, 32'($urandom), b, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for a unit's valid_out before aborting.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op_valid  input  1  R-type instruction in execute this cycle.
REQ-005 funct  input  6  R-type function field.
REQ-006 SrcA, SrcB  input  32 each  rs and rt operands.
REQ-007 mul_validIn, mul_sign  output  1 each  multiplier start request and signed select.
REQ-008 mul_validOut  input  1  multiplier result valid.
REQ-009 mul_Hi, mul_Lo  input  32 each  multiplier result.
REQ-010 div_validIn, div_sign  output  1 each  divider start request and signed select.
REQ-011 div_validOut  input  1  divider result valid.
REQ-012 div_Hi, div_Lo  input  32 each  divider remainder and quotient.
REQ-013 opA, opB  output  32 each  latched operands driven to both units.
REQ-014 stall  output  1  freezes the pipeline front end.
REQ-015 hilo_rd  output  32  MFHI/MFLO result.
REQ-016 Hi, Lo  output  32 each  architectural HI/LO registers.
REQ-017 timeout_err  output  1  sticky watchdog flag.

Function
REQ-018 Decode: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011; all other funct values are ignored.
REQ-019 FSM states: IDLE, MUL_WAIT, DIV_WAIT.
REQ-020 IDLE, op_valid & MULT/MULTU: latch SrcA/SrcB into opA/opB; latch mul_sign = ~funct[0]; clear the watchdog counter; go to MUL_WAIT.
REQ-021 IDLE, op_valid & DIV/DIVU with SrcB != 0: same as REQ-020, but latch div_sign and go to DIV_WAIT.
REQ-022 DIV/DIVU with SrcB == 0: no unit started, Hi/Lo unchanged, stall never asserted, FSM stays IDLE.
REQ-023 stall is combinational. It is 1 in IDLE when a start per REQ-020/021 is decoded. It is 1 in a WAIT state while the unit's validOut is 0. It is 0 otherwise.
REQ-024 mul_validIn = 1 exactly while in MUL_WAIT; div_validIn = 1 exactly while in DIV_WAIT. Both are 0 in IDLE.
REQ-025 MUL_WAIT with mul_validOut = 1: on that edge Hi <= mul_Hi, Lo <= mul_Lo, go to IDLE; stall is 0 in that cycle. DIV_WAIT behaves identically with the div_* signals.
REQ-026 validOut from the unit not being waited on is ignored.
REQ-027 Watchdog counter increments each WAIT cycle. Reaching TIMEOUT without validOut: go to IDLE, Hi/Lo unchanged, timeout_err <= 1 (sticky until reset).
REQ-028 IDLE, op_valid & MTHI: Hi <= SrcA next edge. MTLO: Lo <= SrcA next edge. No stall for either.
REQ-029 hilo_rd combinational: Hi when funct = MFHI, Lo when funct = MFLO, else 0. It reflects the register value before any same-cycle write.
REQ-030 op_valid and funct are ignored while in a WAIT state; the stalled pipeline holds them stable.
REQ-031 Hi and Lo are written only per REQ-025 and REQ-028; both are write-enabled registers with no other update path.
REQ-032 opA/opB hold their value from latch until the next start.

Reset
REQ-033 On reset assertion, immediately: state = IDLE; Hi, Lo, opA, opB = 0; timeout_err = 0; counter = 0; mul_sign, div_sign = 0. stall, mul_validIn and div_validIn then evaluate to 0.
REQ-034 Reset mid-operation aborts the operation with no Hi/Lo write. A validOut arriving after reset is ignored.

Verification
REQ-035 MULT, SrcA = 0xFFFFFFFE, SrcB = 3, model unit 4-cycle latency: stall high 4 cycles; Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFA; mul_sign = 1.
REQ-036 DIVU, SrcA = 100, SrcB = 7: div_sign = 0; after validOut, Lo = 14, Hi = 2; next cycle MFLO gives hilo_rd = 14.
REQ-037 DIV, SrcB = 0: stall stays 0, div_validIn stays 0, Hi/Lo unchanged.
REQ-038 MTHI 0x12345678 then MFHI next cycle: hilo_rd = 0x12345678, no stall.
REQ-039 TIMEOUT = 8 and the unit never responds: stall high 8 cycles, then timeout_err = 1, state = IDLE, Hi/Lo unchanged.
REQ-040 Reset asserted on the 2nd cycle of MUL_WAIT: stall and mul_validIn drop at once, Hi = Lo = 0, and a later validOut does not write Hi/Lo.
